// File: rtl/adc_frame_averager.sv
// -----------------------------------------------------------------------------
// adc_frame_averager
//
// Averages 2^LOG2_N consecutive 8x16-bit ADC frames for each channel. It emits
// one averaged frame and a one-clock avg_tick. A single shared adder handles
// one channel per clock, so each accepted frame takes 9 clocks (8 ACCUM +
// 1 FINISH).
//
// Parameters:
//   LOG2_N    log2 of the number of frames averaged per output (0..8)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-low reset
//   in_tick   one-clock pulse; in_data holds a valid new frame this cycle
//   in_data   8 channels, channel i = in_data[16*i+15:16*i]
//   busy      high while a latched frame is being accumulated
//   avg_tick  one-clock pulse; avg_data was updated on the preceding edge
//   avg_data  averaged frame, same packing as in_data; held between ticks
//   overrun   (only with ADC_FRAME_AVERAGER_OVERRUN_EN) sticky flag; set when
//             a frame arrives while one is still being accumulated
//
// Optional feature macro: ADC_FRAME_AVERAGER_OVERRUN_EN
// -----------------------------------------------------------------------------
module adc_frame_averager #(
  parameter int LOG2_N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_tick,
  input  logic [127:0] in_data,
  output logic         busy,
  output logic         avg_tick,
  output logic [127:0] avg_data
`ifdef ADC_FRAME_AVERAGER_OVERRUN_EN
  ,
  output logic         overrun
`endif
);

  localparam int AW = 16 + LOG2_N;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     ch;
  logic [127:0]   frame;
  logic [AW-1:0]  acc [8];
  logic [15:0]    sample;
  logic [AW-1:0]  sum;
  logic           is_final;
  logic           accept;
  logic           do_accum;
  logic           do_finish;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every register
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_nxt gets a default before the case. Without it, a path that
  // does not assign it would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_tick) state_nxt = ACCUM;
      ACCUM:   if (ch == 3'd7) state_nxt = FINISH;
      // A frame that arrives on the edge that leaves FINISH is taken straight
      // away. The next frame does not lose a cycle to IDLE.
      FINISH:  state_nxt = in_tick ? ACCUM : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state != IDLE);
    accept    = in_tick && ((state == IDLE) || (state == FINISH));
    do_accum  = (state == ACCUM);
    do_finish = (state == FINISH);
  end

  // ---------------------------------------------------------------------------
  // Frame register and channel index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame <= '0;
      ch    <= '0;
    end else if (accept) begin
      frame <= in_data;
      ch    <= '0;
    end else if (do_accum) begin
      ch <= ch + 3'd1;
    end
  end

  // Shared adder: one channel per clock.
  assign sample = frame[{ch, 4'b0000} +: 16];
  assign sum    = acc[ch] + AW'(sample);

  // ---------------------------------------------------------------------------
  // Accumulators
  // ---------------------------------------------------------------------------
  // NOTE: this register array is reset on purpose. A reset during accumulation
  // must discard any partial sums, so an unreset RAM-style array is not enough.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < 8; c++) acc[c] <= '0;
    end else if (do_finish && is_final) begin
      for (int c = 0; c < 8; c++) acc[c] <= '0;
    end else if (do_accum) begin
      acc[ch] <= sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame counter (absent when every frame is final)
  // ---------------------------------------------------------------------------
  if (LOG2_N > 0) begin : g_cnt
    logic [LOG2_N-1:0] cnt;

    always_ff @(posedge clk) begin
      if (!reset)         cnt <= '0;
      else if (do_finish) cnt <= is_final ? '0 : cnt + LOG2_N'(1);
    end

    assign is_final = &cnt;
  end else begin : g_no_cnt
    assign is_final = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Averaged output: floor division by N is a plain bit-select of the sum
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      avg_data <= '0;
      avg_tick <= 1'b0;
    end else begin
      avg_tick <= do_finish && is_final;
      if (do_finish && is_final) begin
        for (int c = 0; c < 8; c++) avg_data[16*c +: 16] <= acc[c][LOG2_N +: 16];
      end
    end
  end

`ifdef ADC_FRAME_AVERAGER_OVERRUN_EN
  // Only a frame that is actually dropped counts. A frame taken on the FINISH
  // edge is accepted, so it does not set the flag.
  always_ff @(posedge clk) begin
    if (!reset)                   overrun <= 1'b0;
    else if (in_tick && do_accum) overrun <= 1'b1;
  end
`endif

endmodule
